// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM status and arbiter state types for the
// cache-to-memory bus.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBUS = 2'd1,
        IBUS = 2'd2
    } bus_state_t;

    // Only ACCESS completes a RAM word; FREE, BUSY and ERROR all stall.
    function automatic logic ram_ready(input ramstate_t status);
        return status == ACCESS;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: two-requester round-robin picker. A lone requester wins; on a
// tie the core that was not served last wins.
module rr_arbiter (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Pick the winner purely from the request pair and the last-served pointer
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: memory-side responder shared by the icache and dcache of two
// cores. Data requests beat instruction requests, a locked data transaction
// keeps the grant across words, and the owner's address is broadcast to the
// other core for snooping.
module bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  word_t [CPUS-1:0]      iaddr,
    output logic [CPUS-1:0]       iwait,
    output word_t [CPUS-1:0]      iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  word_t [CPUS-1:0]      daddr,
    input  word_t [CPUS-1:0]      dstore,
    output logic [CPUS-1:0]       dwait,
    output word_t [CPUS-1:0]      dload,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       ccwait,
    output word_t [CPUS-1:0]      ccsnoopaddr,
    output logic [CPUS-1:0]       ccinv,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate
);

    bus_state_t state, next_state;
    logic       owner, next_owner;
    logic       other;
    logic       d_last, next_d_last;
    logic       i_last, next_i_last;
    logic       ready;

    logic [1:0] data_req;
    logic [1:0] inst_req;
    logic       d_grant, d_valid;
    logic       i_grant, i_valid;

    assign ready    = ram_ready(ramstate);
    assign other    = ~owner;
    assign data_req = dREN | dWEN | cctrans;
    assign inst_req = iREN;

    rr_arbiter u_data_rr (
        .req   (data_req),
        .last  (d_last),
        .grant (d_grant),
        .valid (d_valid)
    );

    rr_arbiter u_inst_rr (
        .req   (inst_req),
        .last  (i_last),
        .grant (i_grant),
        .valid (i_valid)
    );

    // Grant state, owner and per-class pointers; reset favours CPU0 on a tie
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= 1'b0;
            d_last <= 1'b1;
            i_last <= 1'b1;
        end else begin
            state  <= next_state;
            owner  <= next_owner;
            d_last <= next_d_last;
            i_last <= next_i_last;
        end
    end

    // Next grant plus every bus and coherence output for the current owner
    always_comb begin
        next_state  = state;
        next_owner  = owner;
        next_d_last = d_last;
        next_i_last = i_last;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        iload       = {CPUS{ramload}};
        dload       = {CPUS{ramload}};

        case (state)
            IDLE: begin
                if (d_valid) begin
                    next_state = DBUS;
                    next_owner = d_grant;
                end else if (i_valid) begin
                    next_state = IBUS;
                    next_owner = i_grant;
                end
            end

            DBUS: begin
                ramWEN             = dWEN[owner];
                ramREN             = dREN[owner] & ~dWEN[owner];
                ramaddr            = daddr[owner];
                ramstore           = dstore[owner];
                dwait[owner]       = ~(ready & (dREN[owner] | dWEN[owner]));
                ccwait[other]      = cctrans[owner];
                ccsnoopaddr[other] = daddr[owner];
                ccinv[other]       = ccwrite[owner] | dWEN[owner];
                if ((ready && !cctrans[owner]) || !data_req[owner]) begin
                    next_state  = IDLE;
                    next_d_last = owner;
                end
            end

            IBUS: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[owner];
                iwait[owner] = ~ready;
                if (ready || !iREN[owner]) begin
                    next_state  = IDLE;
                    next_i_last = owner;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level model of the arbiter's grant rules.
module tb_bus_arbiter;
    import cpu_types_pkg::*;

    localparam int GRANT_NONE  = 0;
    localparam int GRANT_DATA  = 1;
    localparam int GRANT_INSTR = 2;

    logic            CLK;
    logic            nRST;
    logic [1:0]      iREN;
    word_t [1:0]     iaddr;
    logic [1:0]      iwait;
    word_t [1:0]     iload;
    logic [1:0]      dREN;
    logic [1:0]      dWEN;
    word_t [1:0]     daddr;
    word_t [1:0]     dstore;
    logic [1:0]      dwait;
    word_t [1:0]     dload;
    logic [1:0]      cctrans;
    logic [1:0]      ccwrite;
    logic [1:0]      ccwait;
    word_t [1:0]     ccsnoopaddr;
    logic [1:0]      ccinv;
    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    int checks = 0;
    int errors = 0;

    // Model: who holds the bus, of which class, and who won each class last
    int m_kind;
    int m_core;
    int m_last_data;
    int m_last_instr;

    bus_arbiter #(.CPUS(2)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .dwait       (dwait),
        .dload       (dload),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .ccwait      (ccwait),
        .ccsnoopaddr (ccsnoopaddr),
        .ccinv       (ccinv),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_kind       = GRANT_NONE;
        m_core       = 0;
        m_last_data  = 1;
        m_last_instr = 1;
    endtask

    // Apply the grant rules for one clock edge using the inputs seen at it
    task automatic model_advance();
        int  dq[$];
        int  iq[$];
        bit  ready;
        int  o;
        ready = (ramstate == ACCESS);
        o = m_core;
        if (m_kind == GRANT_NONE) begin
            for (int c = 0; c < 2; c++) begin
                if (dREN[c] || dWEN[c] || cctrans[c]) dq.push_back(c);
                if (iREN[c]) iq.push_back(c);
            end
            if (dq.size() != 0) begin
                m_kind = GRANT_DATA;
                m_core = (dq.size() == 1) ? dq[0] : 1 - m_last_data;
            end else if (iq.size() != 0) begin
                m_kind = GRANT_INSTR;
                m_core = (iq.size() == 1) ? iq[0] : 1 - m_last_instr;
            end
        end else if (m_kind == GRANT_DATA) begin
            if ((ready && !cctrans[o]) || !(dREN[o] || dWEN[o] || cctrans[o])) begin
                m_kind      = GRANT_NONE;
                m_last_data = o;
            end
        end else begin
            if (ready || !iREN[o]) begin
                m_kind       = GRANT_NONE;
                m_last_instr = o;
            end
        end
    endtask

    // Compare every DUT output with what the model says this cycle should show
    task automatic check_model();
        logic [1:0]  e_iwait, e_dwait, e_ccwait, e_ccinv;
        logic        e_ren, e_wen;
        word_t       e_addr, e_store;
        word_t [1:0] e_snoop;
        bit          ready;
        int          o, n;
        ready    = (ramstate == ACCESS);
        e_iwait  = 2'b11;
        e_dwait  = 2'b11;
        e_ccwait = 2'b00;
        e_ccinv  = 2'b00;
        e_ren    = 1'b0;
        e_wen    = 1'b0;
        e_addr   = '0;
        e_store  = '0;
        e_snoop  = '0;
        o = m_core;
        n = 1 - m_core;
        if (m_kind == GRANT_DATA) begin
            e_wen       = dWEN[o];
            e_ren       = dREN[o] && !dWEN[o];
            e_addr      = daddr[o];
            e_store     = dstore[o];
            e_dwait[o]  = !(ready && (dREN[o] || dWEN[o]));
            e_ccwait[n] = cctrans[o];
            e_snoop[n]  = daddr[o];
            e_ccinv[n]  = ccwrite[o] || dWEN[o];
        end else if (m_kind == GRANT_INSTR) begin
            e_ren      = 1'b1;
            e_addr     = iaddr[o];
            e_iwait[o] = !ready;
        end
        checkOutput("m_iwait", iwait, e_iwait);
        checkOutput("m_dwait", dwait, e_dwait);
        checkOutput("m_ccwait", ccwait, e_ccwait);
        checkOutput("m_ccinv", ccinv, e_ccinv);
        checkOutput("m_ramREN", ramREN, e_ren);
        checkOutput("m_ramWEN", ramWEN, e_wen);
        checkOutput("m_ramaddr", ramaddr, e_addr);
        checkOutput("m_ramstore", ramstore, e_store);
        checkOutput("m_snoop", ccsnoopaddr, e_snoop);
        checkOutput("m_iload", iload, {ramload, ramload});
        checkOutput("m_dload", dload, {ramload, ramload});
    endtask

    // Let the inputs driven at the falling edge settle, then check the model
    task automatic applyStimulus();
        #1;
        check_model();
    endtask

    task automatic end_cycle();
        @(posedge CLK);
        if (nRST) model_advance();
        else model_reset();
        @(negedge CLK);
    endtask

    task automatic clear_requests();
        iREN    = '0;
        dREN    = '0;
        dWEN    = '0;
        cctrans = '0;
        ccwrite = '0;
    endtask

    initial begin
        int r;
        nRST     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = 32'h0;
        ramstate = FREE;
        clear_requests();
        model_reset();

        $display("[TB] reset state");
        applyStimulus();
        checkOutput("rst_iwait", iwait, 2'b11);
        checkOutput("rst_dwait", dwait, 2'b11);
        checkOutput("rst_strobes", {ramREN, ramWEN}, 2'b00);
        end_cycle();
        nRST = 1'b1;

        $display("[TB] instruction fetch CPU0");
        iREN = 2'b01; iaddr[0] = 32'h0000_0040; ramload = 32'h1234_5678;
        applyStimulus();
        checkOutput("if_idle_ren", ramREN, 1'b0);
        end_cycle();
        ramstate = ACCESS;
        applyStimulus();
        checkOutput("if_ren", ramREN, 1'b1);
        checkOutput("if_addr", ramaddr, 32'h40);
        checkOutput("if_iwait", iwait, 2'b10);
        checkOutput("if_iload", iload[0], 32'h1234_5678);
        end_cycle();
        clear_requests(); ramstate = FREE;
        applyStimulus();
        end_cycle();

        $display("[TB] data tie between cores");
        dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20;
        applyStimulus();
        end_cycle();
        ramstate = BUSY;
        applyStimulus();
        checkOutput("tie1_addr", ramaddr, 32'h10);
        checkOutput("tie1_busy_dwait", dwait, 2'b11);
        end_cycle();
        ramstate = ACCESS;
        applyStimulus();
        checkOutput("tie1_dwait", dwait, 2'b10);
        end_cycle();
        applyStimulus();
        checkOutput("tie_turnaround_dwait", dwait, 2'b11);
        end_cycle();
        applyStimulus();
        checkOutput("tie2_addr", ramaddr, 32'h20);
        checkOutput("tie2_dwait", dwait, 2'b01);
        end_cycle();
        clear_requests();
        applyStimulus();
        end_cycle();

        $display("[TB] locked writeback plus fill on CPU0");
        cctrans = 2'b01; dWEN = 2'b01; daddr[0] = 32'h100; dstore[0] = 32'hA0A0_0100;
        applyStimulus();
        checkOutput("lock_idle_ccwait", ccwait, 2'b00);
        end_cycle();
        for (int w = 0; w < 4; w++) begin
            if (w == 2) begin
                dWEN = 2'b00; dREN = 2'b01;
            end
            daddr[0]  = (w < 2) ? 32'h100 + 32'(4 * w) : 32'h200 + 32'(4 * (w - 2));
            dstore[0] = 32'hA0A0_0000 + daddr[0];
            ramload   = 32'hB0B0_0000 + daddr[0];
            applyStimulus();
            checkOutput("lock_strobe", {ramREN, ramWEN}, (w < 2) ? 2'b01 : 2'b10);
            checkOutput("lock_addr", ramaddr, daddr[0]);
            checkOutput("lock_ccwait", ccwait, 2'b10);
            checkOutput("lock_snoop", ccsnoopaddr[1], daddr[0]);
            checkOutput("lock_dwait", dwait, 2'b10);
            end_cycle();
        end
        clear_requests();
        applyStimulus();
        checkOutput("lock_release_ccwait", ccwait, 2'b00);
        end_cycle();
        applyStimulus();
        end_cycle();

        $display("[TB] data beats instruction");
        dREN = 2'b10; daddr[1] = 32'h300; iREN = 2'b01; iaddr[0] = 32'h80;
        applyStimulus();
        end_cycle();
        applyStimulus();
        checkOutput("col_daddr", ramaddr, 32'h300);
        checkOutput("col_dwait", dwait, 2'b01);
        checkOutput("col_iwait_d", iwait, 2'b11);
        end_cycle();
        dREN = 2'b00;
        applyStimulus();
        checkOutput("col_iwait_idle", iwait, 2'b11);
        end_cycle();
        applyStimulus();
        checkOutput("col_iaddr", ramaddr, 32'h80);
        checkOutput("col_iwait_i", iwait, 2'b10);
        end_cycle();
        clear_requests();
        applyStimulus();
        end_cycle();

        $display("[TB] write with invalidate hint");
        dWEN = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h400; dstore[0] = 32'hDEAD_BEEF;
        ramstate = BUSY;
        applyStimulus();
        end_cycle();
        applyStimulus();
        checkOutput("inv_store", ramstore, 32'hDEAD_BEEF);
        checkOutput("inv_ccinv", ccinv, 2'b10);
        end_cycle();
        ramstate = ACCESS;
        applyStimulus();
        checkOutput("inv_dwait", dwait, 2'b10);
        end_cycle();
        clear_requests();
        applyStimulus();
        end_cycle();

        $display("[TB] reset during a stalled write");
        dWEN = 2'b01; daddr[0] = 32'h500; ramstate = BUSY;
        applyStimulus();
        end_cycle();
        applyStimulus();
        checkOutput("rstmid_wen_before", ramWEN, 1'b1);
        nRST = 1'b0;
        model_reset();
        #1;
        checkOutput("rstmid_wen", ramWEN, 1'b0);
        checkOutput("rstmid_dwait", dwait, 2'b11);
        checkOutput("rstmid_iwait", iwait, 2'b11);
        check_model();
        end_cycle();
        nRST = 1'b1;
        clear_requests();
        dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700; ramstate = ACCESS;
        applyStimulus();
        end_cycle();
        applyStimulus();
        checkOutput("rstmid_cpu0_addr", ramaddr, 32'h600);
        checkOutput("rstmid_cpu0_dwait", dwait, 2'b10);
        end_cycle();
        clear_requests();
        applyStimulus();
        end_cycle();

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 400; cyc++) begin
            iREN     = 2'($urandom);
            dREN     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            dWEN     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            cctrans  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            ccwrite  = 2'($urandom);
            iaddr    = {$urandom, $urandom};
            daddr    = {$urandom, $urandom};
            dstore   = {$urandom, $urandom};
            ramload  = $urandom;
            r = $urandom_range(0, 9);
            if (r < 5) ramstate = ACCESS;
            else if (r < 8) ramstate = BUSY;
            else if (r == 8) ramstate = FREE;
            else ramstate = ERROR;
            applyStimulus();
            end_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
